// File: rtl/wb_select_unit.sv
// wb_select_unit: write-back source selector and register-file write driver.
//
// Accepts one retired instruction per ex_valid/ex_ready handshake and produces
// a registered one-cycle register-file write. The write value is the ALU
// result, PC+4, or an aligned and extended load word taken from the
// data-memory read response.
//
// Ports:
//   clk, rst_n           core clock, asynchronous active-low reset
//   ex_valid / ex_ready  instruction handshake from execute
//   ex_rd, ex_pc         destination register and instruction PC
//   alu_result           ALU result (effective byte address for loads)
//   wb_select            0 ALU, 1 PC+4, 2 LOAD, 3 NONE
//   load_funct3          LB/LH/LW/LBU/LHU encoding
//   mem_rvalid/mem_rdata data-memory read response (aligned word)
//   rf_we/rf_rd/rf_wdata registered register-file write port
//   wb_fault             one-cycle pulse on a misaligned or illegal load
module wb_select_unit #(
    parameter int XLEN         = 32,
    parameter int SEL_WB_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ex_valid,
    output logic                    ex_ready,
    input  logic [4:0]              ex_rd,
    input  logic [XLEN-1:0]         ex_pc,
    input  logic [XLEN-1:0]         alu_result,
    input  logic [SEL_WB_WIDTH-1:0] wb_select,
    input  logic [2:0]              load_funct3,
    input  logic                    mem_rvalid,
    input  logic [XLEN-1:0]         mem_rdata,
    output logic                    rf_we,
    output logic [4:0]              rf_rd,
    output logic [XLEN-1:0]         rf_wdata,
    output logic                    wb_fault
);

    localparam logic [SEL_WB_WIDTH-1:0] SEL_ALU  = SEL_WB_WIDTH'(0);
    localparam logic [SEL_WB_WIDTH-1:0] SEL_PC4  = SEL_WB_WIDTH'(1);
    localparam logic [SEL_WB_WIDTH-1:0] SEL_LOAD = SEL_WB_WIDTH'(2);

    typedef enum logic {S_IDLE, S_WAIT_MEM} state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [4:0]      r_rd;
    logic [2:0]      r_funct3;
    logic [1:0]      r_off;
    logic            w_accept;
    logic            w_direct;
    logic            w_load;
    logic            w_illegal;
    logic            w_misaligned;
    logic            w_load_fault;
    logic            w_load_go;
    logic            w_mem_done;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load_data;

    always_comb begin
        w_accept     = ex_valid && ex_ready;
        w_direct     = (wb_select == SEL_ALU) || (wb_select == SEL_PC4);
        w_load       = wb_select == SEL_LOAD;
        w_illegal    = (load_funct3 == 3'b011) || (load_funct3[2:1] == 2'b11);
        w_misaligned = ((load_funct3[1:0] == 2'b01) && alu_result[0]) ||
                       ((load_funct3 == 3'b010) && (alu_result[1:0] != 2'b00));
        w_load_fault = w_accept && w_load && (w_illegal || w_misaligned);
        w_load_go    = w_accept && w_load && !w_illegal && !w_misaligned;
        w_mem_done   = (r_state == S_WAIT_MEM) && mem_rvalid;
    end

    // Only legal funct3 values are ever latched: bit1 set means LW,
    // bit0 set means halfword, otherwise byte; bit2 selects zero-extension.
    always_comb begin
        w_byte      = mem_rdata[{r_off, 3'b000} +: 8];
        w_half      = mem_rdata[{r_off[1], 4'b0000} +: 16];
        w_load_data = r_funct3[1] ? mem_rdata :
                      r_funct3[0] ? {{16{~r_funct3[2] & w_half[15]}}, w_half} :
                                    {{24{~r_funct3[2] & w_byte[7]}}, w_byte};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (r_state == S_IDLE)
            w_next_state = w_load_go ? S_WAIT_MEM : S_IDLE;
        else
            w_next_state = mem_rvalid ? S_IDLE : S_WAIT_MEM;
    end

    always_comb begin
        ex_ready = r_state == S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd     <= '0;
            r_funct3 <= '0;
            r_off    <= '0;
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
            wb_fault <= 1'b0;
        end else begin
            rf_we    <= 1'b0;
            wb_fault <= w_load_fault;
            if (w_accept && w_direct) begin
                rf_rd    <= ex_rd;
                rf_wdata <= (wb_select == SEL_PC4) ? ex_pc + XLEN'(4) : alu_result;
                rf_we    <= ex_rd != 5'd0;
            end
            if (w_load_go) begin
                r_rd     <= ex_rd;
                r_funct3 <= load_funct3;
                r_off    <= alu_result[1:0];
            end
            if (w_mem_done) begin
                rf_rd    <= r_rd;
                rf_wdata <= w_load_data;
                rf_we    <= r_rd != 5'd0;
            end
        end
    end

endmodule

// File: tb/tb_wb_select_unit.sv
// tb_wb_select_unit: scoreboard bench for wb_select_unit with a behavioural load model.
module tb_wb_select_unit;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic [31:0] ex_pc;
    logic [31:0] alu_result;
    logic [1:0]  wb_select;
    logic [2:0]  load_funct3;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic        wb_fault;

    wb_select_unit #(.XLEN(32), .SEL_WB_WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_rd(ex_rd), .ex_pc(ex_pc), .alu_result(alu_result),
        .wb_select(wb_select), .load_funct3(load_funct3),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .wb_fault(wb_fault)
    );

    typedef struct {
        bit          fault;
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } ev_t;

    ev_t         q[$];
    ev_t         e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          busy = 0;
    logic [4:0]  p_rd;
    logic [2:0]  p_f3;
    logic [1:0]  p_off;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
        int unsigned b = (w >> (8 * off)) & 32'hFF;
        int unsigned h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? b - 256 : b;
            3'b001:  return (h >= 32768) ? h - 65536 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic bit is_fault(input logic [2:0] f3, input logic [31:0] a);
        bit illegal = (f3 == 3) || (f3 >= 6);
        bit mis = ((f3 == 1 || f3 == 5) && (a % 2 != 0)) || (f3 == 2 && (a % 4 != 0));
        return illegal || mis;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_event actual=none required=%s rd=%0d data=%h at cycle %0d",
                         q[0].fault ? "fault" : "write", q[0].rd, q[0].data, q[0].cyc);
                void'(q.pop_front());
            end
            if (rf_we || wb_fault) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event actual=we%0b fault%0b rd=%0d data=%h required=none cycle %0d",
                             rf_we, wb_fault, rf_rd, rf_wdata, cyc);
                end else begin
                    e = q.pop_front();
                    if (e.fault != wb_fault || e.fault == rf_we || e.cyc != cyc ||
                        (!e.fault && (rf_rd !== e.rd || rf_wdata !== e.data))) begin
                        errors++;
                        $display("FAIL event actual=we%0b fault%0b rd=%0d data=%h cyc=%0d required=%s rd=%0d data=%h cyc=%0d",
                                 rf_we, wb_fault, rf_rd, rf_wdata, cyc,
                                 e.fault ? "fault" : "write", e.rd, e.data, e.cyc);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [2:0] f3);
        chk("ex_ready", {31'd0, ex_ready}, {31'd0, !busy});
        ex_valid = 1; wb_select = sel; ex_rd = rd; ex_pc = pc; alu_result = alu; load_funct3 = f3;
        if (!busy) begin
            if (sel < 2 && rd != 0)
                q.push_back('{1'b0, rd, (sel == 1) ? pc + 32'd4 : alu, cyc + 1});
            else if (sel == 2 && is_fault(f3, alu))
                q.push_back('{1'b1, 5'd0, 32'd0, cyc + 1});
            else if (sel == 2) begin
                busy = 1; p_rd = rd; p_f3 = f3; p_off = alu[1:0];
            end
        end
        @(negedge clk);
        ex_valid = 0;
    endtask

    task automatic respond(input int delay, input logic [31:0] data);
        repeat (delay) begin
            if ($urandom_range(0, 1) == 1)
                issue(2'($urandom_range(0, 3)), 5'($urandom_range(1, 31)), $urandom, $urandom & 32'hFFFF_FFFC, 3'b010);
            else begin
                chk("ex_ready_wait", {31'd0, ex_ready}, 32'd0);
                @(negedge clk);
            end
        end
        chk("ex_ready_resp", {31'd0, ex_ready}, 32'd0);
        mem_rvalid = 1; mem_rdata = data;
        if (p_rd != 0) q.push_back('{1'b0, p_rd, load_val(p_f3, p_off, data), cyc + 1});
        busy = 0;
        @(negedge clk);
        mem_rvalid = 0; mem_rdata = $urandom;
    endtask

    initial begin
        rst_n = 0; ex_valid = 0; ex_rd = 0; ex_pc = 0; alu_result = 0; wb_select = 0;
        load_funct3 = 0; mem_rvalid = 0; mem_rdata = 0;
        repeat (3) @(negedge clk);
        chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
        chk("reset_rf_rd", {27'd0, rf_rd}, 32'd0);
        chk("reset_rf_wdata", rf_wdata, 32'd0);
        chk("reset_wb_fault", {31'd0, wb_fault}, 32'd0);
        chk("reset_ex_ready", {31'd0, ex_ready}, 32'd1);
        rst_n = 1;
        @(negedge clk);

        issue(0, 5, 32'h0, 32'h0000_000A, 0);
        chk("alu_wdata", rf_wdata, 32'h0000_000A);
        issue(1, 1, 32'h0000_0020, 32'h0, 0);
        chk("pc4_wdata", rf_wdata, 32'h0000_0024);
        issue(1, 1, 32'hFFFF_FFFC, 32'h0, 0);
        chk("pc4_wrap", rf_wdata, 32'h0000_0000);
        issue(0, 0, 32'h0, 32'h0000_1234, 0);
        chk("x0_wdata", rf_wdata, 32'h0000_1234);
        chk("x0_we", {31'd0, rf_we}, 32'd0);

        issue(2, 7, 0, 32'h103, 3'b000); respond(0, 32'h80F0_7F81); chk("lb", rf_wdata, 32'hFFFF_FF80);
        issue(2, 8, 0, 32'h100, 3'b100); respond(1, 32'h80F0_7F81); chk("lbu", rf_wdata, 32'h0000_0081);
        issue(2, 9, 0, 32'h102, 3'b001); respond(2, 32'h80F0_7F81); chk("lh", rf_wdata, 32'hFFFF_80F0);
        issue(2, 10, 0, 32'h100, 3'b101); respond(0, 32'h80F0_7F81); chk("lhu", rf_wdata, 32'h0000_7F81);
        issue(2, 11, 0, 32'h100, 3'b010); respond(5, 32'h80F0_7F81); chk("lw", rf_wdata, 32'h80F0_7F81);

        mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_rvalid = 0;
        issue(2, 3, 0, 32'h102, 3'b010);
        issue(2, 3, 0, 32'h100, 3'b011);
        issue(0, 4, 0, 32'h55, 0);

        issue(2, 9, 0, 32'h200, 3'b010);
        @(negedge clk);
        rst_n = 0;
        #1;
        busy = 0;
        chk("rst_mid_we", {31'd0, rf_we}, 32'd0);
        chk("rst_mid_wdata", rf_wdata, 32'd0);
        chk("rst_mid_ready", {31'd0, ex_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_rvalid = 0;
        chk("post_rst_we", {31'd0, rf_we}, 32'd0);
        chk("post_rst_ready", {31'd0, ex_ready}, 32'd1);
        chk("post_rst_rd", {27'd0, rf_rd}, 32'd0);

        for (int i = 0; i < 400; i++) begin
            logic [1:0] s = 2'($urandom_range(0, 3));
            logic [4:0] r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            issue(s, r, $urandom & 32'hFFFF_FFFC, $urandom, 3'($urandom_range(0, 7)));
            if (busy) respond($urandom_range(0, 4), $urandom);
            else if ($urandom_range(0, 9) == 0) begin
                mem_rvalid = 1;
                @(negedge clk);
                mem_rvalid = 0;
            end
        end

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 pending events", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_select_unit.md
# wb_select_unit

Write-back result selector and register-file write driver for the TinyRisc-V core. It sits at the output end of the execute datapath, opposite the ALU operand-source muxes. It accepts one retired instruction per handshake from execute and chooses the write value: ALU result, PC+4, or load data. For loads it waits for the data-memory read response and aligns and extends the returned word. It then drives a registered single-cycle register-file write pulse.

## Interface
Parameters:
- XLEN, 32, datapath width (only 32 supported).
- SEL_WB_WIDTH, 2, width of the write-back select code.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ex_valid  input  1  execute presents an instruction.
- ex_ready  output  1  unit can accept an instruction.
- ex_rd  input  5  destination register index.
- ex_pc  input  XLEN  PC of the instruction.
- alu_result  input  XLEN  ALU result; for loads, the effective byte address.
- wb_select  input  SEL_WB_WIDTH  source code: 0 = ALU, 1 = PC+4, 2 = LOAD, 3 = NONE.
- load_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- mem_rvalid  input  1  data-memory read response valid.
- mem_rdata  input  XLEN  aligned 32-bit word from data memory.
- rf_we  output  1  register-file write enable, one-cycle pulse.
- rf_rd  output  5  register-file write index.
- rf_wdata  output  XLEN  register-file write data.
- wb_fault  output  1  one-cycle pulse for a misaligned or illegal load.

## Operation
- The FSM has two states: IDLE and WAIT_MEM. ex_ready = (state == IDLE), decoded combinationally from state.
- Accept condition: ex_valid && ex_ready at a rising edge.
- Accept with wb_select 0: rf_wdata <= alu_result.
- Accept with wb_select 1: rf_wdata <= ex_pc + 4, modulo 2^32; 0xFFFFFFFC wraps to 0x00000000.
- Accept with wb_select 0 or 1: rf_rd <= ex_rd and rf_we <= (ex_rd != 0). Writes to x0 are suppressed, but rf_rd and rf_wdata still update.
- Accept with wb_select 3: no write and no state change.
- Accept with wb_select 2, misaligned (LH/LHU with addr[0]=1, or LW with addr[1:0]!=0) or illegal funct3 (011, 110, 111): wb_fault pulses next cycle, no write, remain in IDLE.
- Accept with wb_select 2, legal: latch rd, funct3 and addr[1:0], then go to WAIT_MEM.
- WAIT_MEM: ex_valid is ignored. On mem_rvalid, select a byte or halfword by the latched offset:
  - byte = rdata[8*off +: 8];
  - half = rdata[16*off[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Register the result into rf_wdata, pulse rf_we (subject to the x0 rule), and return to IDLE.
- mem_rvalid in IDLE is ignored.
- rf_we and wb_fault are registered and deassert after one cycle unless re-asserted by a new event.
- Reset values: state IDLE, rf_we 0, rf_rd 0, rf_wdata 0, wb_fault 0, all latches 0. ex_ready is therefore 1 after reset.
- Reset during WAIT_MEM: the pending load is dropped with no write. A mem_rvalid arriving after reset release is ignored.

## Timing
- Non-load accepted at edge k: rf_we/rf_rd/rf_wdata valid in the cycle after edge k. Latency is 1, throughput is 1 per cycle; back-to-back accepts give rf_we high continuously.
- Load accepted at edge k: ex_ready is low from edge k. mem_rvalid may arrive in the cycle right after edge k or any later cycle, with no timeout.
- mem_rvalid sampled at edge m: rf_we high for the cycle after edge m, and ex_ready high in that same cycle. A new instruction can be accepted at edge m+1.
- Minimum load occupancy is 2 cycles, accept to next accept.
- wb_fault is a one-cycle pulse in the cycle after the faulting accept. ex_ready stays high throughout.
- Asynchronous reset forces all outputs to reset values immediately, regardless of clk.

## Test plan
- ALU path: ex_rd=5, alu_result=0x0000000A, wb_select=0 -> next cycle rf_we=1, rf_rd=5, rf_wdata=0x0000000A.
- PC+4 and x0 cases:
  - ex_pc=0x00000020, wb_select=1, ex_rd=1 -> rf_wdata=0x00000024.
  - ex_pc=0xFFFFFFFC -> rf_wdata=0x00000000.
  - Same with ex_rd=0 -> rf_we=0.
- Load extension, each case with mem_rdata=0x80F0_7F81:
  - LB at addr 0x103 -> 0xFFFFFF80.
  - LBU at addr 0x100 -> 0x00000081.
  - LH at addr 0x102 -> 0xFFFF80F0.
  - LHU at addr 0x100 -> 0x00007F81.
  - LW at addr 0x100 -> 0x80F07F81.
  - In every case ex_ready stays low until the cycle after mem_rvalid.
- Load wait: mem_rvalid delayed 5 cycles -> ex_ready low for 5 cycles, and ex_valid pulses during the wait are not accepted. A spurious mem_rvalid in IDLE produces no rf_we.
- Faults: LW at addr 0x102 -> wb_fault pulse, no rf_we, ex_ready stays 1. funct3=011 gives the same result.
- Reset mid-load: assert rst_n=0 in WAIT_MEM, release, then pulse mem_rvalid -> no rf_we, outputs 0, ex_ready=1.
